// File: rtl/rr_arb8_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the arbiter state encoding and the rotating-priority winner search.
package rr_arb8_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_t;

   // First set request bit scanning upward from ptr, wrapping 7 -> 0.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [IDX_W-1:0] ptr
   );
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] win;
      logic             found;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + IDX_W'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_arb8_dec_dec3to8_en.sv
// Combinational 3-to-8 decoder with enable, built from two 2-to-4 halves.
// Bit 2 of sel picks which half is enabled; the output is all-zero when en=0.
module dec3to8_en (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] y
);

   logic [1:0] half_en;

   assign half_en = {en & sel[2], en & ~sel[2]};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_half
         assign y[gi*4 +: 4] = half_en[gi] ? (4'b0001 << sel[1:0]) : 4'b0000;
      end
   endgenerate

endmodule

// File: rtl/rr_arb8_dec.sv
// Round-robin arbiter for 8 requesters with a hold-time limit per owner.
// The owner index is registered and expanded to a one-hot grant bus by dec3to8_en.
module rr_arb8_dec
   import rr_arb8_pkg::*;
#(
   parameter  int MAX_HOLD = 16,
   localparam int HOLD_W   = $clog2(MAX_HOLD)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             expire
);

   arb_state_t        state_reg,    state_next;
   logic [IDX_W-1:0]  ptr_reg,      ptr_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic [IDX_W-1:0]  gnt_idx_reg,  gnt_idx_next;
   logic              gnt_vld_reg,  gnt_vld_next;
   logic              expire_reg,   expire_next;

   logic owner_req;
   logic timeout;
   logic release_now;

   assign owner_req   = req[gnt_idx_reg];
   assign timeout     = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
   assign release_now = done | ~owner_req | timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         hold_cnt_reg <= '0;
         gnt_idx_reg  <= '0;
         gnt_vld_reg  <= 1'b0;
         expire_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         hold_cnt_reg <= hold_cnt_next;
         gnt_idx_reg  <= gnt_idx_next;
         gnt_vld_reg  <= gnt_vld_next;
         expire_reg   <= expire_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      hold_cnt_next = hold_cnt_reg;
      gnt_idx_next  = gnt_idx_reg;
      gnt_vld_next  = gnt_vld_reg;
      expire_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               state_next    = GRANT;
               gnt_idx_next  = rr_pick(req, ptr_reg);
               gnt_vld_next  = 1'b1;
               hold_cnt_next = '0;
            end
         end

         GRANT: begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            if (release_now) begin
               state_next    = GAP;
               gnt_vld_next  = 1'b0;
               hold_cnt_next = '0;
               ptr_next      = gnt_idx_reg + IDX_W'(1);
               // An explicit finish or a dropped request takes precedence over timeout.
               expire_next   = timeout & ~done & owner_req;
            end
         end

         GAP: begin
            state_next = IDLE;
         end

         default: begin
            state_next   = IDLE;
            gnt_vld_next = 1'b0;
         end
      endcase
   end

   assign gnt_idx = gnt_idx_reg;
   assign gnt_vld = gnt_vld_reg;
   assign expire  = expire_reg;

   dec3to8_en u_dec (
      .sel (gnt_idx_reg),
      .en  (gnt_vld_reg),
      .y   (gnt)
   );

endmodule

// File: tb/tb_rr_arb8_dec.sv
// Directed bench for rr_arb8_dec: reset, rotation, timeout, drop, priority, async reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rr_arb8_dec;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       expire;

   int passed = 0;
   int total  = 0;

   rr_arb8_dec #(.MAX_HOLD(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .expire  (expire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] e_gnt,
                          input logic e_vld, input logic e_exp);
      chk({tag, ".gnt"},    gnt,           e_gnt);
      chk({tag, ".vld"},    {7'd0, gnt_vld}, {7'd0, e_vld});
      chk({tag, ".expire"}, {7'd0, expire},  {7'd0, e_exp});
      $display("%-12s gnt=%h idx=%0d vld=%0b expire=%0b", tag, gnt, gnt_idx, gnt_vld, expire);
   endtask

   initial begin
      logic [7:0] exp_gnt;

      // 1: reset with every requester active
      rst_n = 1'b0;
      req   = 8'hFF;
      done  = 1'b0;
      tick();
      tick();
      chk_out("reset", 8'h00, 1'b0, 1'b0);
      chk("reset.idx", {5'd0, gnt_idx}, 8'd0);
      rst_n = 1'b1;
      tick();
      chk_out("first_gnt", 8'h01, 1'b1, 1'b0);
      chk("first_gnt.idx", {5'd0, gnt_idx}, 8'd0);

      // 2: rotation with done pulsed once per grant, including wrap 7 -> 0
      for (int k = 0; k < 8; k++) begin
         done = 1'b1;
         tick();
         done = 1'b0;
         chk_out("rot_gap", 8'h00, 1'b0, 1'b0);
         tick();
         chk_out("rot_idle", 8'h00, 1'b0, 1'b0);
         tick();
         exp_gnt = 8'h01 << ((k + 1) % 8);
         chk_out("rot_gnt", exp_gnt, 1'b1, 1'b0);
      end

      // 3: timeout with a single requester holding on
      req = 8'h08;             // owner 0 drops its request: implicit release
      tick();
      chk_out("drop_gap", 8'h00, 1'b0, 1'b0);
      tick();
      chk_out("drop_idle", 8'h00, 1'b0, 1'b0);
      tick();
      chk_out("to_c1", 8'h08, 1'b1, 1'b0);
      for (int c = 2; c <= 16; c++) begin
         tick();
         chk_out("to_hold", 8'h08, 1'b1, 1'b0);
      end
      tick();
      chk_out("to_gap", 8'h00, 1'b0, 1'b1);
      tick();
      chk_out("to_idle", 8'h00, 1'b0, 1'b0);
      tick();
      chk_out("to_regnt", 8'h08, 1'b1, 1'b0);
      chk("to_regnt.idx", {5'd0, gnt_idx}, 8'd3);

      // 4: drop + done coinciding with the timeout cycle -> no expire
      req = 8'h04;
      tick();
      chk_out("sw_gap", 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      chk_out("own2_c1", 8'h04, 1'b1, 1'b0);
      for (int c = 2; c <= 16; c++) begin
         tick();
         chk_out("own2_hold", 8'h04, 1'b1, 1'b0);
      end
      req  = 8'h00;
      done = 1'b1;
      tick();
      chk_out("sim_gap", 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      chk_out("idle_done", 8'h00, 1'b0, 1'b0);
      chk("idle_done.idx", {5'd0, gnt_idx}, 8'd2);
      done = 1'b0;

      // 5: owner 5 released leaves ptr=6; req 0x41 -> idx 6 then 0
      req = 8'h20;
      tick();
      chk_out("own5", 8'h20, 1'b1, 1'b0);
      req = 8'h41;
      tick();
      tick();
      tick();
      chk_out("pri_6", 8'h40, 1'b1, 1'b0);
      chk("pri_6.idx", {5'd0, gnt_idx}, 8'd6);
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      tick();
      chk_out("pri_0", 8'h01, 1'b1, 1'b0);
      chk("pri_0.idx", {5'd0, gnt_idx}, 8'd0);

      // 6: async reset between edges while granting; ptr is 7 before reset
      req = 8'h81;
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("areset", 8'h00, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_out("post_rst", 8'h01, 1'b1, 1'b0);
      chk("post_rst.idx", {5'd0, gnt_idx}, 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
